// File: rtl/cbus_pkg.sv
// Shared types for the core bus arbiter.
// Request/response bundles mirror the memory-side port fields.
package cbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_I = 3'd1,
    ST_ADDR_D = 3'd2,
    ST_DATA_I = 3'd3,
    ST_DATA_D = 3'd4
  } arb_state_t;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Shares one memory port between fetch (ibus) and data (dbus).
// One outstanding transaction; dbus priority with fetch anti-starvation.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_data,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_data
);

  localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

  arb_state_t r_state;
  arb_state_t w_next;
  logic [3:0] r_starve;
  logic       w_i_win;
  logic       w_sel_i;
  logic       w_sel_d;
  logic       w_acc;
  cbus_req_t  w_req;
  cbus_resp_t w_ri;
  cbus_resp_t w_rd;

  // Pick which bus drives the memory port this cycle.
  always_comb begin
    w_i_win = i_valid && (!d_valid || (r_starve >= LP_STARVE));
    w_sel_i = 1'b0;
    w_sel_d = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_sel_i = w_i_win;
        w_sel_d = d_valid && !w_i_win;
      end
      ST_ADDR_I: w_sel_i = i_valid;
      ST_ADDR_D: w_sel_d = d_valid;
      default: ;
    endcase
  end

  // Next state, request forwarding and response routing.
  always_comb begin
    w_next = r_state;
    w_req  = '0;
    w_ri   = '0;
    w_rd   = '0;
    w_acc  = (w_sel_i || w_sel_d) && m_addr_ok;
    if (w_sel_i) begin
      w_req.valid = 1'b1;
      w_req.addr  = i_addr;
      w_req.size  = SIZE_WORD;
    end else if (w_sel_d) begin
      w_req.valid  = 1'b1;
      w_req.addr   = d_addr;
      w_req.size   = d_size;
      w_req.strobe = d_strobe;
      w_req.wdata  = d_wdata;
    end
    unique case (r_state)
      ST_IDLE, ST_ADDR_I, ST_ADDR_D: begin
        if (w_sel_i) begin
          if (m_addr_ok) begin
            w_ri.addr_ok = 1'b1;
            if (m_data_ok) begin
              w_ri.data_ok = 1'b1;
              w_ri.data    = m_data;
              w_next       = ST_IDLE;
            end else begin
              w_next = ST_DATA_I;
            end
          end else begin
            w_next = ST_ADDR_I;
          end
        end else if (w_sel_d) begin
          if (m_addr_ok) begin
            w_rd.addr_ok = 1'b1;
            if (m_data_ok) begin
              w_rd.data_ok = 1'b1;
              w_rd.data    = m_data;
              w_next       = ST_IDLE;
            end else begin
              w_next = ST_DATA_D;
            end
          end else begin
            w_next = ST_ADDR_D;
          end
        end else begin
          // Owner abandoned its request: release the port silently.
          w_next = ST_IDLE;
        end
      end
      ST_DATA_I: begin
        if (m_data_ok) begin
          w_ri.data_ok = 1'b1;
          w_ri.data    = m_data;
          w_next       = ST_IDLE;
        end
      end
      ST_DATA_D: begin
        if (m_data_ok) begin
          w_rd.data_ok = 1'b1;
          w_rd.data    = m_data;
          w_next       = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Count dbus grants that made a waiting fetch lose; saturate at 15.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_starve <= 4'd0;
    end else if (w_acc) begin
      if (w_sel_i)
        r_starve <= 4'd0;
      else if (i_valid && (r_starve != 4'hf))
        r_starve <= r_starve + 4'd1;
    end
  end

  assign m_valid   = !resetn && w_req.valid;
  assign m_addr    = resetn ? 32'd0 : w_req.addr;
  assign m_size    = resetn ? 3'd0  : w_req.size;
  assign m_strobe  = resetn ? 4'd0  : w_req.strobe;
  assign m_wdata   = resetn ? 32'd0 : w_req.wdata;
  assign i_addr_ok = !resetn && w_ri.addr_ok;
  assign i_data_ok = !resetn && w_ri.data_ok;
  assign i_data    = resetn ? 32'd0 : w_ri.data;
  assign d_addr_ok = !resetn && w_rd.addr_ok;
  assign d_data_ok = !resetn && w_rd.data_ok;
  assign d_data    = resetn ? 32'd0 : w_rd.data;

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares one memory port between the fetch stage's instruction bus and the memory stage's data bus.
- Sits between MyCore and the memory/cache interface; every ibus and dbus transaction passes through it.
- Enforces one outstanding transaction, routes responses back to the owner, and prevents fetch starvation behind a stream of loads and stores.

Parameters:
- STARVE_MAX, 4, consecutive dbus wins while ibus waits before ibus is forced to win the next arbitration (1..15).

Ports:
- clk  in  1  clock
- resetn  in  1  reset; one clock; reset is asynchronous and active-high (resetn=1 holds reset)
- i_valid  in  1  ibus request valid
- i_addr  in  32  ibus address
- i_addr_ok  out  1  ibus address accepted
- i_data_ok  out  1  ibus read data valid
- i_data  out  32  ibus read data
- d_valid  in  1  dbus request valid
- d_addr  in  32  dbus address
- d_size  in  3  dbus access size code
- d_strobe  in  4  byte write strobe; 0 means read
- d_wdata  in  32  dbus write data
- d_addr_ok  out  1  dbus address accepted
- d_data_ok  out  1  dbus response valid
- d_data  out  32  dbus read data
- m_valid  out  1  memory request valid
- m_addr  out  32  memory address
- m_size  out  3  memory access size
- m_strobe  out  4  memory byte strobe
- m_wdata  out  32  memory write data
- m_addr_ok  in  1  memory accepted address
- m_data_ok  in  1  memory response valid
- m_data  in  32  memory read data

Behaviour:
- States: IDLE, ADDR_I, ADDR_D, DATA_I, DATA_D, held in a 3-bit state register.
- Reset: state=IDLE, starve counter=0. While resetn=1, all outputs are 0.
- IDLE winner selection:
  - d_valid wins over i_valid.
  - Exception: if starve counter >= STARVE_MAX and i_valid=1, ibus wins.
- IDLE forwarding: the winner's request is forwarded combinationally to m_* in the same cycle (zero added latency).
  - ibus forwarding drives m_size=3'b010, m_strobe=0, m_wdata=0.
  - No valid request: m_valid=0 and m_* fields are 0.
- IDLE transitions:
  - Winner forwarded and m_addr_ok=1: the winner's *_addr_ok=1 that cycle; go to DATA_x.
  - Winner forwarded and m_addr_ok=0: go to ADDR_x, which locks the owner.
- ADDR_x: forwards only the owner's request, even if the other bus raises valid.
  - The requester must hold valid and payload stable until addr_ok; the arbiter does not check this.
  - m_addr_ok=1: pulse the owner's *_addr_ok and go to DATA_x.
  - Owner drops valid without addr_ok (protocol violation): go to IDLE, no response issued.
- DATA_x: m_valid=0.
  - m_data_ok=1: *_data_ok=1 and *_data=m_data go to the owner only; go to IDLE.
  - The next arbitration happens in the cycle after data_ok. No back-to-back overlap.
- Same cycle m_addr_ok=1 and m_data_ok=1 while in IDLE/ADDR_x: forward both pulses to the owner and stay in or return to IDLE.
- m_data_ok while in IDLE with no grant: ignored, not forwarded.
- Non-owner always sees addr_ok=0 and data_ok=0; its data output is 0.
- Starve counter (4-bit, saturating at 15), updated on each grant accepted with m_addr_ok:
  - dbus accepted while i_valid=1: +1.
  - ibus accepted: cleared to 0.
  - dbus accepted while i_valid=0: unchanged.
- Reset asserted mid-transaction: state returns to IDLE immediately and asynchronously; the in-flight response is dropped. Memory is reset by the same resetn.

Decomposition:
- Shared package cbus_pkg: state enum arb_state_t, constant SIZE_WORD=3'b010, flattened cbus_req_t/cbus_resp_t structs matching the m_* fields.
- No sub-module needed; arbitration, FSM and counter fit in one module.
- Optional extraction: a small starve_counter sub-module.

Test Plan:
- Lone fetch: i_valid=1, i_addr=32'hbfc0_0000, m_addr_ok same cycle, m_data_ok 2 cycles later with 32'h2408_0001 -> i_addr_ok pulse at cycle 0, i_data_ok with i_data=32'h2408_0001 at cycle 2, d_* outputs stay 0.
- Simultaneous requests: i_valid=d_valid=1, d_addr=32'h8000_0010, d_strobe=4'hf, d_wdata=32'hdead_beef -> m_addr=32'h8000_0010 and m_strobe=4'hf first; ibus is granted the cycle after d_data_ok.
- Lock under stall: d_valid raised while ibus is in ADDR_I with m_addr_ok held 0 for 3 cycles -> m_addr stays i_addr throughout, d_addr_ok stays 0.
- Starvation, STARVE_MAX=4: i_valid held 1, five back-to-back dbus requests -> exactly 4 dbus grants, then the ibus grant, counter clears.
- Same-cycle handshake: m_addr_ok=m_data_ok=1 in IDLE for a dbus read -> d_addr_ok and d_data_ok both 1 that cycle, state IDLE next cycle.
- Reset mid-op: resetn asserted in DATA_D, then m_data_ok=1 after release -> no d_data_ok, all outputs 0 during reset, next i_valid granted normally.
